// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one synchronous single-port video RAM between the pixel fetcher
//   and the CPU. Video reads always take the slot and have a fixed one-cycle
//   latency. CPU accesses use the remaining cycles. CPU writes go into a
//   one-entry posted buffer and are acknowledged at once. CPU reads are
//   acknowledged when the RAM data comes back.
//
//   Ports
//     clk_pixel, nreset      : pixel clock and synchronous active-low reset
//     vid_rd, vid_addr       : video read strobe and address
//     vid_data               : video read data, valid the cycle after vid_rd, then held
//     cpu_req/we/addr/wdata  : CPU request (level); fields are stable until cpu_ack
//     cpu_ack, cpu_rdata     : one-cycle completion pulse and registered read data
//     mem_addr/we/wdata      : RAM address, write enable and write data
//     mem_rdata              : RAM read data, valid the cycle after its address
//
//   Slot owner per cycle, highest priority first
//     slot      | meaning
//     SLOT_VID  | video read; vid_addr drives the RAM
//     SLOT_WR   | drain the posted write buffer into the RAM
//     SLOT_CRD  | issue a new CPU read (buffer empty, no read in flight)
//     SLOT_IDLE | nothing to do; cpu_addr is parked on the RAM address
//
//   owner_q remembers the previous slot, so the returning mem_rdata can be
//   steered to the right consumer.
//     owner    | meaning
//     OWN_NONE | last cycle returned no useful data
//     OWN_VID  | last cycle was a video read
//     OWN_CPU  | last cycle was a CPU read (read in flight)

module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_pixel,
  input  logic              nreset,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_VID  = 2'd1,
    SLOT_WR   = 2'd2,
    SLOT_CRD  = 2'd3
  } slot_e;

  owner_e              owner_q, owner_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DATA_W-1:0]   vid_hold_q, vid_hold_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

  slot_e               slot;
  logic                new_req;
  logic                rd_in_flight;
  logic                wr_accept;

  always_ff @(posedge clk_pixel) begin
    if (!nreset) begin
      owner_q     <= OWN_NONE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      vid_hold_q  <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      vid_hold_q  <= vid_hold_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  always_comb begin
    slot        = SLOT_IDLE;
    owner_d     = OWN_NONE;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    vid_hold_d  = vid_hold_q;
    cpu_rdata_d = cpu_rdata_q;
    mem_addr    = cpu_addr;
    mem_we      = 1'b0;
    mem_wdata   = wb_data_q;
    vid_data    = vid_hold_q;

    // While cpu_ack is high the same request is still on the bus and must
    // not be taken a second time.
    new_req      = cpu_req & ~cpu_ack_q;
    rd_in_flight = (owner_q == OWN_CPU);
    wr_accept    = new_req & cpu_we & ~wb_valid_q;

    // A CPU read waits for the buffer to drain, so it always returns the
    // newest write.
    if (vid_rd) begin
      slot = SLOT_VID;
    end else if (wb_valid_q) begin
      slot = SLOT_WR;
    end else if (new_req && !cpu_we && !rd_in_flight) begin
      slot = SLOT_CRD;
    end

    case (slot)
      SLOT_VID: begin
        mem_addr = vid_addr;
        owner_d  = OWN_VID;
      end
      SLOT_WR: begin
        mem_addr   = wb_addr_q;
        mem_we     = nreset;
        wb_valid_d = 1'b0;
      end
      SLOT_CRD: begin
        owner_d = OWN_CPU;
      end
      default: begin
        owner_d = OWN_NONE;
      end
    endcase

    // wr_accept needs an empty buffer, so it never races with the drain.
    if (wr_accept) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = cpu_addr;
      wb_data_d  = cpu_wdata;
    end

    cpu_ack_d = wr_accept | rd_in_flight;
    if (rd_in_flight) begin
      cpu_rdata_d = mem_rdata;
    end

    if (owner_q == OWN_VID) begin
      vid_data   = mem_rdata;
      vid_hold_d = mem_rdata;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a synchronous RAM model plus a memory-image
// reference (shadow) that holds what each address must contain once all
// acknowledged CPU writes are applied.

module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk_pixel = 1'b0;
  logic          nreset;
  logic          vid_rd;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] ram    [0:65535];
  logic [DW-1:0] shadow [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk_pixel = ~clk_pixel;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .vid_rd    (vid_rd),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) ^ (a >> 5) ^ 8'h5A);
  endfunction

  // Synchronous single-port RAM, read-first, one-cycle read latency.
  initial begin
    for (int a = 0; a < 65536; a++) ram[a] <= init_val(a);
    mem_rdata <= '0;
    forever begin
      @(posedge clk_pixel);
      if (bd_we) ram[bd_addr] <= bd_data;
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_pixel);
  endtask

  task automatic backdoor_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tick();
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'hEE;
    vid_rd = 1'b0; vid_addr = '0;
    for (int i = 0; i < 2; i++) begin
      tick(); sample();
      checks++;
      if (mem_we !== 1'b0) begin
        errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we);
      end
    end
    tick();
    nreset = 1'b1; cpu_req = 1'b0;
    sample();
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_rel_mem_we: got %b expected 0", mem_we); end
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b expected 0", cpu_ack); end
    checks++;
    if (vid_data !== 8'h00) begin errors++; $display("FAIL reset_vid_data: got %h expected 00", vid_data); end
    checks++;
    if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 00", cpu_rdata); end
    tick(); sample();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack2: got %b expected 0", cpu_ack); end
  endtask

  task automatic test_video_read();
    backdoor_write(16'h1234, 8'hA5);
    tick();
    vid_rd = 1'b1; vid_addr = 16'h1234;
    sample();
    checks++;
    if (mem_addr !== 16'h1234 || mem_we !== 1'b0) begin
      errors++; $display("FAIL vid_slot: got addr %h we %b expected 1234 0", mem_addr, mem_we);
    end
    tick();
    vid_rd = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    sample();
    checks++;
    if (vid_data !== 8'hA5) begin errors++; $display("FAIL vid_n1: got %h expected a5", vid_data); end
    tick(); sample();
    checks++;
    if (vid_data !== 8'hA5) begin errors++; $display("FAIL vid_hold_cpu_return: got %h expected a5", vid_data); end
    tick();
    cpu_req = 1'b0;
    sample();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== shadow[16'h0010]) begin
      errors++; $display("FAIL vid_test_cpu_read: got ack %b data %h expected 1 %h", cpu_ack, cpu_rdata, shadow[16'h0010]);
    end
    for (int i = 3; i <= 5; i++) begin
      checks++;
      if (vid_data !== 8'hA5) begin errors++; $display("FAIL vid_hold_n%0d: got %h expected a5", i, vid_data); end
      tick(); sample();
    end
  endtask

  task automatic test_posted_write();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h3C;
    shadow[16'h0100] = 8'h3C;
    sample();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_n: got %b expected 0", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    sample();
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack_n1: got %b expected 1", cpu_ack); end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 8'h3C) begin
      errors++; $display("FAIL wr_commit: got we %b addr %h data %h expected 1 0100 3c", mem_we, mem_addr, mem_wdata);
    end
    tick(); sample();
    checks++;
    if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL wr_after: got ack %b we %b expected 0 0", cpu_ack, mem_we);
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    sample();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_n: got %b expected 0", cpu_ack); end
    tick(); sample();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rd_ack_n1: got %b expected 0", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    sample();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL rd_after_wr: got ack %b data %h expected 1 3c", cpu_ack, cpu_rdata);
    end
  endtask

  task automatic test_video_priority();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
    shadow[16'h0200] = 8'h5A;
    tick();  // N: write acked, buffer full; switch the request to a read
    cpu_we = 1'b0;
    vid_rd = 1'b1; vid_addr = 16'h9000;
    sample();
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL prio_n: got ack %b we %b expected 1 0", cpu_ack, mem_we);
    end
    tick();  // N+1
    vid_addr = 16'h9001;
    sample();
    checks++;
    if (mem_we !== 1'b0 || vid_data !== shadow[16'h9000]) begin
      errors++; $display("FAIL prio_n1: got we %b vid %h expected 0 %h", mem_we, vid_data, shadow[16'h9000]);
    end
    tick();  // N+2
    vid_rd = 1'b0;
    sample();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0200 || vid_data !== shadow[16'h9001]) begin
      errors++; $display("FAIL prio_n2: got we %b addr %h vid %h expected 1 0200 %h", mem_we, mem_addr, vid_data, shadow[16'h9001]);
    end
    tick(); sample();  // N+3: read issues
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 16'h0200 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL prio_n3: got we %b addr %h ack %b expected 0 0200 0", mem_we, mem_addr, cpu_ack);
    end
    tick(); sample();  // N+4: read data returning
    checks++;
    if (cpu_ack !== 1'b0 || vid_data !== shadow[16'h9001]) begin
      errors++; $display("FAIL prio_n4: got ack %b vid %h expected 0 %h", cpu_ack, vid_data, shadow[16'h9001]);
    end
    tick();  // N+5: acknowledged
    cpu_req = 1'b0;
    sample();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      errors++; $display("FAIL prio_ack: got ack %b data %h expected 1 5a", cpu_ack, cpu_rdata);
    end
  endtask

  task automatic test_interleave();
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_rd, vid_exp, vid_chk_val;
    bit vid_pend, vid_chk;
    int last_ack, acks;
    rd_addr = 16'h0100; exp_rd = shadow[rd_addr];
    vid_pend = 1'b0; vid_exp = '0; last_ack = 0; acks = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      vid_chk = vid_pend; vid_chk_val = vid_exp;
      if (cpu_ack) begin
        checks++;
        if (cpu_rdata !== exp_rd) begin
          errors++; $display("FAIL il_cpu_rdata addr %h: got %h expected %h", rd_addr, cpu_rdata, exp_rd);
        end
        checks++;
        if (c - last_ack > 4) begin
          errors++; $display("FAIL il_ack_gap: got %0d idle cycles expected at most 3", c - last_ack - 1);
        end
        last_ack = c; acks++;
        rd_addr = rd_addr + 16'd1;
        exp_rd = shadow[rd_addr];
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = rd_addr;
      vid_rd = (c % 2 == 0);
      vid_addr = 16'h8000 | 16'($urandom_range(0, 32767));
      vid_pend = vid_rd; vid_exp = shadow[vid_addr];
      sample();
      if (vid_chk) begin
        checks++;
        if (vid_data !== vid_chk_val) begin
          errors++; $display("FAIL il_vid_data: got %h expected %h", vid_data, vid_chk_val);
        end
      end
    end
    checks++;
    if (acks < 12) begin errors++; $display("FAIL il_ack_count: got %0d expected at least 12", acks); end
    tick();
    cpu_req = 1'b0; vid_rd = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_random_mix();
    bit busy, cur_we, vid_pend, vid_chk;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data, exp_rd, vid_exp, vid_chk_val;
    int wait_cnt;
    busy = 1'b0; cur_we = 1'b0; vid_pend = 1'b0; vid_exp = '0; exp_rd = '0; wait_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      vid_chk = vid_pend; vid_chk_val = vid_exp;
      if (cpu_ack) begin
        checks++;
        if (!busy) begin
          errors++; $display("FAIL rnd_spurious_ack: got 1 expected 0");
        end else if (!cur_we && cpu_rdata !== exp_rd) begin
          errors++; $display("FAIL rnd_cpu_rdata addr %h: got %h expected %h", cur_addr, cpu_rdata, exp_rd);
        end
        busy = 1'b0; cpu_req = 1'b0;
      end else if (busy) begin
        wait_cnt++;
        if (wait_cnt > 20) begin
          checks++; errors++;
          $display("FAIL rnd_ack_timeout addr %h: got no ack expected ack within 20 cycles", cur_addr);
          busy = 1'b0; cpu_req = 1'b0;
        end
      end
      if (!busy && cyc < 370 && $urandom_range(0, 1) == 1) begin
        busy = 1'b1; wait_cnt = 0;
        cur_we = 1'($urandom_range(0, 1));
        cur_addr = 16'($urandom_range(0, 63));
        cur_data = 8'($urandom);
        cpu_req = 1'b1; cpu_we = cur_we; cpu_addr = cur_addr; cpu_wdata = cur_data;
        if (cur_we) shadow[cur_addr] = cur_data;
        else exp_rd = shadow[cur_addr];
      end
      vid_rd = vid_pend ? 1'b0 : 1'($urandom_range(0, 1));
      vid_addr = 16'h8000 | 16'($urandom_range(0, 32767));
      vid_pend = vid_rd; vid_exp = shadow[vid_addr];
      sample();
      if (vid_chk) begin
        checks++;
        if (vid_data !== vid_chk_val) begin
          errors++; $display("FAIL rnd_vid_data: got %h expected %h", vid_data, vid_chk_val);
        end
      end
      if (vid_rd) begin
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== vid_addr) begin
          errors++; $display("FAIL rnd_vid_priority: got we %b addr %h expected 0 %h", mem_we, mem_addr, vid_addr);
        end
      end
    end
    cpu_req = 1'b0; vid_rd = 1'b0;
    repeat (4) tick();
    for (int a = 0; a < 64; a++) begin
      checks++;
      if (ram[a] !== shadow[a]) begin
        errors++; $display("FAIL rnd_ram_image addr %h: got %h expected %h", a[15:0], ram[a], shadow[a]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    backdoor_write(16'h0300, 8'h11);
    tick();  // N
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h77;
    tick();  // N+1: ack, keep the slot busy with video so the buffer cannot drain
    cpu_req = 1'b0;
    vid_rd = 1'b1; vid_addr = 16'h8000;
    sample();
    checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rmf_ack: got ack %b we %b expected 1 0", cpu_ack, mem_we);
    end
    tick();  // N+2: reset while the write is still buffered
    nreset = 1'b0; vid_rd = 1'b0;
    sample();
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL rmf_mem_we_rst: got %b expected 0", mem_we); end
    tick();
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL rmf_after_rst: got ack %b we %b expected 0 0", cpu_ack, mem_we);
      end
      tick();
    end
    checks++;
    if (ram[16'h0300] !== 8'h11) begin
      errors++; $display("FAIL rmf_ram_unchanged: got %h expected 11", ram[16'h0300]);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    sample();
    checks++;
    if (mem_addr !== 16'h0300 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rmf_rd_issue: got addr %h we %b expected 0300 0", mem_addr, mem_we);
    end
    tick();  // read in flight; reset drops it
    nreset = 1'b0; cpu_req = 1'b0;
    tick();
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if (cpu_ack !== 1'b0 || cpu_rdata !== 8'h00) begin
        errors++; $display("FAIL rmf_rd_dropped: got ack %b data %h expected 0 00", cpu_ack, cpu_rdata);
      end
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) shadow[a] = init_val(a);
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    cpu_wdata = '0;
    test_reset();
    test_video_read();
    test_posted_write();
    test_video_priority();
    test_interleave();
    test_random_mix();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
